// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S playback timing/sample-scheduling path.
package i2s_pkg;

  localparam int SCLK_WS_RATIO_DEF   = 64;
  localparam int MCLK_SCLK_RATIO_DEF = 4;
  localparam int DATA_W_DEF          = 24;
  localparam int UNDERRUN_CNT_W      = 16;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] left;
    logic [DATA_W_DEF-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_frame_ctrl_if.sv
// Stereo sample handshake between the effects chain (master) and the frame controller (slave).
interface i2s_frame_ctrl_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);

endinterface

// File: rtl/i2s_clk_div.sv
// Divides mclk into sclk/ws and decodes the one-cycle shift/sample/frame strobes.
// All outputs are registered from the next counter state, so they track mc/bc glitch-free.
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int SCLK_WS_RATIO   = SCLK_WS_RATIO_DEF,
  parameter int MCLK_SCLK_RATIO = MCLK_SCLK_RATIO_DEF
) (
  input  logic mclk,
  input  logic reset_n,
  input  logic enable,
  output logic sclk,
  output logic ws,
  output logic shift_stb,
  output logic sample_stb,
  output logic frame_stb,
  output logic frame_edge
);

  localparam int MC_W = (MCLK_SCLK_RATIO > 2) ? $clog2(MCLK_SCLK_RATIO) : 1;
  localparam int BC_W = $clog2(SCLK_WS_RATIO);

  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MCLK_SCLK_RATIO - 1);
  localparam logic [MC_W-1:0] MC_HALF = MC_W'(MCLK_SCLK_RATIO / 2);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(SCLK_WS_RATIO - 1);
  localparam logic [BC_W-1:0] WS_LO   = BC_W'(SCLK_WS_RATIO / 2 - 1);
  localparam logic [BC_W-1:0] WS_HI   = BC_W'(SCLK_WS_RATIO - 2);

  logic [MC_W-1:0] mc, mc_nxt;
  logic [BC_W-1:0] bc, bc_nxt;
  logic            mc_wrap;

  assign mc_wrap    = enable && (mc == MC_LAST);
  assign frame_edge = mc_wrap && (bc == BC_LAST);

  // Disabled counters sit at the state one mclk before the left-MSB frame edge.
  always_comb begin
    mc_nxt = '0;
    bc_nxt = BC_LAST;
    if (enable) begin
      mc_nxt = mc_wrap ? '0 : mc + MC_W'(1);
      bc_nxt = bc;
      if (mc_wrap) begin
        bc_nxt = (bc == BC_LAST) ? '0 : bc + BC_W'(1);
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      mc         <= '0;
      bc         <= BC_LAST;
      sclk       <= 1'b0;
      ws         <= 1'b0;
      shift_stb  <= 1'b0;
      sample_stb <= 1'b0;
      frame_stb  <= 1'b0;
    end else begin
      mc         <= mc_nxt;
      bc         <= bc_nxt;
      sclk       <= (mc_nxt >= MC_HALF);
      ws         <= (bc_nxt >= WS_LO) && (bc_nxt <= WS_HI);
      shift_stb  <= mc_wrap;
      sample_stb <= enable && (mc_nxt == MC_HALF);
      frame_stb  <= frame_edge;
    end
  end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S playback frame controller: clock/strobe generation, one-entry stereo buffer, underrun count.
// Build option I2S_CTRL_HOLD_LAST_EN: repeat the last pair on underrun instead of muting.
module i2s_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int SCLK_WS_RATIO   = SCLK_WS_RATIO_DEF,
  parameter int MCLK_SCLK_RATIO = MCLK_SCLK_RATIO_DEF,
  parameter int DATA_W          = DATA_W_DEF
) (
  input  logic                      mclk,
  input  logic                      reset_n,
  input  logic                      enable,
  i2s_frame_ctrl_if.slave           src,
  output logic                      sclk,
  output logic                      ws,
  output logic                      shift_stb,
  output logic                      sample_stb,
  output logic                      frame_stb,
  output logic [DATA_W-1:0]         tx_left,
  output logic [DATA_W-1:0]         tx_right,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

  logic                      frame_edge;
  logic                      accept;
  logic                      buf_full;
  logic [DATA_W-1:0]         buf_left;
  logic [DATA_W-1:0]         buf_right;
  logic [UNDERRUN_CNT_W-1:0] underrun_q;

  i2s_clk_div #(
    .SCLK_WS_RATIO  (SCLK_WS_RATIO),
    .MCLK_SCLK_RATIO(MCLK_SCLK_RATIO)
  ) u_clk_div (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .enable    (enable),
    .sclk      (sclk),
    .ws        (ws),
    .shift_stb (shift_stb),
    .sample_stb(sample_stb),
    .frame_stb (frame_stb),
    .frame_edge(frame_edge)
  );

  // A full buffer can still accept on the consume edge, since its pair leaves that same edge.
  assign src.in_ready = !buf_full || frame_edge;
  assign accept       = src.in_valid && src.in_ready;
  assign underrun_cnt = underrun_q;

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      buf_full   <= 1'b0;
      buf_left   <= '0;
      buf_right  <= '0;
      tx_left    <= '0;
      tx_right   <= '0;
      underrun_q <= '0;
    end else begin
      if (frame_edge) begin
        if (buf_full) begin
          tx_left  <= buf_left;
          tx_right <= buf_right;
        end else begin
`ifdef I2S_CTRL_HOLD_LAST_EN
`else
          tx_left  <= '0;
          tx_right <= '0;
`endif
          if (underrun_q != '1) begin
            underrun_q <= underrun_q + 1'b1;
          end
        end
      end
      // An accept on an empty-buffer consume edge is stored, never bypassed to tx.
      if (accept) begin
        buf_full  <= 1'b1;
        buf_left  <= src.in_left;
        buf_right <= src.in_right;
      end else if (frame_edge) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed self-checking bench for i2s_frame_ctrl at default ratios (4 mclk/sclk, 64 sclk/frame).
module tb_i2s_frame_ctrl;
  import i2s_pkg::*;

  localparam int DW = 24;
`ifdef I2S_CTRL_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          mclk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          sclk, ws, shift_stb, sample_stb, frame_stb;
  logic [DW-1:0] tx_left, tx_right;
  logic [15:0]   underrun_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  i2s_frame_ctrl_if #(.DATA_W(DW)) src_if ();

  i2s_frame_ctrl #(
    .SCLK_WS_RATIO  (64),
    .MCLK_SCLK_RATIO(4),
    .DATA_W         (DW)
  ) dut (
    .mclk        (mclk),
    .reset_n     (reset_n),
    .enable      (enable),
    .src         (src_if),
    .sclk        (sclk),
    .ws          (ws),
    .shift_stb   (shift_stb),
    .sample_stb  (sample_stb),
    .frame_stb   (frame_stb),
    .tx_left     (tx_left),
    .tx_right    (tx_right),
    .underrun_cnt(underrun_cnt)
  );

  always #5 mclk = ~mclk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
    src_if.in_valid = v;
    src_if.in_left  = l;
    src_if.in_right = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPair(input string tag, input stereo_sample_t exp_pair);
    checkOutput({tag, "_left"}, 32'(tx_left), 32'(exp_pair.left));
    checkOutput({tag, "_right"}, 32'(tx_right), 32'(exp_pair.right));
  endtask

  initial begin
    stereo_sample_t pair_a, pair_b, pair_c, pair_d, pair_e, exp_pair;
    int shifts, samples, frames, sclk_high, ws_rise, ws_fall, tx_changes, strobes, j;
    logic prev_ws;
    logic [DW-1:0] prev_tx;

    pair_a = '{left: 24'h123456, right: 24'hABCDEF};
    pair_b = '{left: 24'h111111, right: 24'h222222};
    pair_c = '{left: 24'h333333, right: 24'h444444};
    pair_d = '{left: 24'h555555, right: 24'h666666};
    pair_e = '{left: 24'h777777, right: 24'h888888};

    reset_n = 1'b0;
    enable  = 1'b0;
    applyStimulus(1'b0, '0, '0);
    step(3);
    reset_n = 1'b1;
    step();
    checkOutput("rst_sclk", 32'(sclk), 32'd0);
    checkOutput("rst_ws", 32'(ws), 32'd0);
    checkOutput("rst_strobes", {29'd0, shift_stb, sample_stb, frame_stb}, 32'd0);
    checkPair("rst_tx", '0);
    checkOutput("rst_in_ready", 32'(src_if.in_ready), 32'd1);
    checkOutput("rst_underrun", 32'(underrun_cnt), 32'd0);

    // First frame: pair pushed before enable edge, frame_stb four cycles later
    enable = 1'b1;
    applyStimulus(1'b1, pair_a.left, pair_a.right);
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput($sformatf("start_frame_stb_%0d", i), 32'(frame_stb), 32'(i == 4));
      checkOutput($sformatf("start_shift_stb_%0d", i), 32'(shift_stb), 32'(i == 4));
      checkOutput($sformatf("start_sample_stb_%0d", i), 32'(sample_stb), 32'(i == 2));
      checkOutput($sformatf("start_sclk_%0d", i), 32'(sclk), 32'(i == 2 || i == 3));
      if (i == 1) begin
        checkOutput("in_ready_full", 32'(src_if.in_ready), 32'd0);
        applyStimulus(1'b0, '0, '0);
      end
    end
    checkPair("first_tx", pair_a);
    checkOutput("first_in_ready", 32'(src_if.in_ready), 32'd1);
    checkOutput("first_underrun", 32'(underrun_cnt), 32'd0);

    // One full frame of strobe/ws statistics
    shifts = 0; samples = 0; frames = 0; sclk_high = 0;
    ws_rise = -1; ws_fall = -1; tx_changes = 0;
    prev_ws = ws;
    prev_tx = tx_left;
    for (int k = 1; k <= 256; k++) begin
      step();
      if (shift_stb) shifts++;
      if (sample_stb) samples++;
      if (frame_stb) frames++;
      if (sclk) sclk_high++;
      if (ws && !prev_ws) ws_rise = k;
      if (!ws && prev_ws) ws_fall = k;
      if (k < 256 && tx_left !== prev_tx) tx_changes++;
      prev_ws = ws;
      prev_tx = tx_left;
    end
    checkOutput("frame_shift_count", 32'(shifts), 32'd64);
    checkOutput("frame_sample_count", 32'(samples), 32'd64);
    checkOutput("frame_frame_count", 32'(frames), 32'd1);
    checkOutput("frame_sclk_high", 32'(sclk_high), 32'd128);
    checkOutput("ws_rise_cycle", 32'(ws_rise), 32'd124);
    checkOutput("ws_fall_cycle", 32'(ws_fall), 32'd252);
    checkOutput("tx_stable", 32'(tx_changes), 32'd0);
    checkOutput("frame2_stb", 32'(frame_stb), 32'd1);
    checkOutput("underrun_1", 32'(underrun_cnt), 32'd1);
    exp_pair = HOLD ? pair_a : '0;
    checkPair("underrun_1_tx", exp_pair);

    // Back-to-back pushes: second stalls until the consume edge
    applyStimulus(1'b1, pair_b.left, pair_b.right);
    step();
    applyStimulus(1'b1, pair_c.left, pair_c.right);
    checkOutput("b2b_stall", 32'(src_if.in_ready), 32'd0);
    j = 1;
    while (src_if.in_ready !== 1'b1 && j < 300) begin
      step();
      j++;
    end
    checkOutput("b2b_ready_cycle", 32'(j), 32'd255);
    step();
    applyStimulus(1'b0, '0, '0);
    checkOutput("b2b_frame_stb", 32'(frame_stb), 32'd1);
    checkPair("b2b_tx_first", pair_b);
    checkOutput("b2b_in_ready", 32'(src_if.in_ready), 32'd0);
    step(256);
    checkOutput("b2b_frame_stb2", 32'(frame_stb), 32'd1);
    checkPair("b2b_tx_second", pair_c);
    checkOutput("b2b_in_ready2", 32'(src_if.in_ready), 32'd1);
    checkOutput("b2b_underrun", 32'(underrun_cnt), 32'd1);

    // Three starved frames
    exp_pair = HOLD ? pair_c : '0;
    for (int f = 1; f <= 3; f++) begin
      step(256);
      checkOutput($sformatf("starve_underrun_%0d", f), 32'(underrun_cnt), 32'(1 + f));
      checkPair($sformatf("starve_tx_%0d", f), exp_pair);
    end

    // Accept on the consume edge with an empty buffer
    step(255);
    applyStimulus(1'b1, pair_d.left, pair_d.right);
    checkOutput("edge_in_ready", 32'(src_if.in_ready), 32'd1);
    step();
    applyStimulus(1'b0, '0, '0);
    checkOutput("edge_underrun", 32'(underrun_cnt), 32'd5);
    checkPair("edge_tx_no_bypass", exp_pair);
    checkOutput("edge_in_ready_after", 32'(src_if.in_ready), 32'd0);
    step(256);
    checkPair("edge_tx_next", pair_d);
    checkOutput("edge_underrun_next", 32'(underrun_cnt), 32'd5);

    // Saturation of the underrun counter
    force dut.underrun_q = 16'hFFFE;
    #1;
    release dut.underrun_q;
    checkOutput("sat_preload", 32'(underrun_cnt), 32'h0000FFFE);
    step(256);
    checkOutput("sat_reach", 32'(underrun_cnt), 32'h0000FFFF);
    step(256);
    checkOutput("sat_hold", 32'(underrun_cnt), 32'h0000FFFF);
    exp_pair = HOLD ? pair_d : '0;
    checkPair("sat_tx", exp_pair);

    // Enable low mid-frame: counters reset, buffer/tx/count held, handshake live
    step(10);
    checkOutput("mid_sclk", 32'(sclk), 32'd1);
    applyStimulus(1'b1, pair_e.left, pair_e.right);
    step();
    applyStimulus(1'b0, '0, '0);
    enable = 1'b0;
    step();
    checkOutput("dis_sclk", 32'(sclk), 32'd0);
    checkOutput("dis_ws", 32'(ws), 32'd0);
    checkOutput("dis_strobes", {29'd0, shift_stb, sample_stb, frame_stb}, 32'd0);
    checkPair("dis_tx_held", exp_pair);
    checkOutput("dis_underrun_held", 32'(underrun_cnt), 32'h0000FFFF);
    checkOutput("dis_in_ready", 32'(src_if.in_ready), 32'd0);
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (shift_stb || sample_stb || frame_stb || sclk || ws) strobes++;
    end
    checkOutput("dis_quiet", 32'(strobes), 32'd0);

    // Reset with a full buffer drops the pair
    reset_n = 1'b0;
    step();
    checkOutput("mrst_in_ready", 32'(src_if.in_ready), 32'd1);
    checkOutput("mrst_underrun", 32'(underrun_cnt), 32'd0);
    checkPair("mrst_tx", '0);
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput($sformatf("restart_frame_stb_%0d", i), 32'(frame_stb), 32'(i == 4));
    end
    checkOutput("restart_underrun", 32'(underrun_cnt), 32'd1);
    checkPair("restart_tx", '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2s_frame_ctrl.md
# i2s_frame_ctrl

Timing and sample-scheduling controller for the I2S playback path. Divides `mclk` into the serial bit clock and word-select, emits one-cycle strobes that tell the I2S shifter when to load, shift and capture, and owns a one-entry stereo sample buffer between the effects chain and the shifter. Handles source underrun deterministically and counts underruns for debug.

## Interface
- `SCLK_WS_RATIO`, 64, `sclk` periods per stereo frame; even, ≥ 2·`DATA_W`.
- `MCLK_SCLK_RATIO`, 4, `mclk` cycles per `sclk` period; even, ≥ 2.
- `DATA_W`, 24, sample width per channel.
- `mclk` in 1: only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: run; low freezes all counters in reset state.
- `in_valid` in 1, `in_ready` out 1: stereo sample handshake.
- `in_left`, `in_right` in `DATA_W`: sample pair.
- `sclk` out 1: bit clock.
- `ws` out 1: word select (0 = left).
- `shift_stb` out 1: one `mclk` pulse per `sclk` falling edge.
- `sample_stb` out 1: one `mclk` pulse per `sclk` rising edge (RX capture).
- `frame_stb` out 1: pulse on the falling edge starting the left MSB.
- `tx_left`, `tx_right` out `DATA_W`: pair the shifter loads on `frame_stb`.
- `underrun_cnt` out 16: saturating underrun count.

## Operation
- `mc`: 0..`MCLK_SCLK_RATIO`−1, increments every cycle while `enable`, wraps to 0.
- `bc`: 0..`SCLK_WS_RATIO`−1, increments on each `mc` wrap, wraps to 0.
- `sclk` = (`mc` ≥ `MCLK_SCLK_RATIO`/2); registered, glitch-free.
- `ws` = 1 for `bc` in [`SCLK_WS_RATIO`/2−1, `SCLK_WS_RATIO`−2], else 0. `ws` leads the MSB by one `sclk`, per I2S.
- `shift_stb`: high in the cycle after each `mc` wrap, i.e. `mc`==0 reached from `MCLK_SCLK_RATIO`−1.
- `frame_stb` = `shift_stb` and `bc`==0.
- `sample_stb`: high when `mc`==`MCLK_SCLK_RATIO`/2.
- Consume edge: the clock edge where `mc`==`MCLK_SCLK_RATIO`−1 and `bc`==`SCLK_WS_RATIO`−1.
  - Buffer full: `tx_left`/`tx_right` take the buffer contents and the buffer empties.
  - Buffer empty (underrun): outputs take the underrun value and `underrun_cnt` increments, saturating at 0xFFFF.
- `in_ready` = buffer empty OR consume edge this cycle. Accept on `in_valid && in_ready`.
  - Simultaneous accept and consume of a full buffer: old pair goes out, new pair fills the buffer.
  - Accept on consume edge while buffer empty: counted as an underrun; new pair is stored and goes out at the next frame. No bypass.
- `enable` low:
  - Forces `mc`=0, `bc`=`SCLK_WS_RATIO`−1, `sclk`=0, `ws`=0 and all strobes 0.
  - Buffer, `tx_*` and `underrun_cnt` are held; the handshake stays live.

## Timing
- Reset values:
  - `mc`=0, `bc`=`SCLK_WS_RATIO`−1.
  - `sclk`=0, `ws`=0, all strobes 0.
  - `tx_left`=`tx_right`=0, buffer empty, `in_ready`=1, `underrun_cnt`=0.
- First `frame_stb` comes exactly `MCLK_SCLK_RATIO` cycles after `enable` rises.
- Frame period is `MCLK_SCLK_RATIO`·`SCLK_WS_RATIO` cycles (256 at defaults).
- `tx_*` change only on the edge that raises `frame_stb` and are stable for the whole frame.
- Accept-to-output latency: the first frame boundary after acceptance.
- Reset mid-frame drops the buffered pair; the next frame starts per reset timing.

## Configuration
- `I2S_CTRL_HOLD_LAST_EN` defined: on underrun, `tx_*` keep their previous values (sample repeat).
- Undefined: on underrun, `tx_*` load 0 (mute).
- Counting is identical in both builds.

## Structure
- Shared package `i2s_pkg`:
  - default ratio and width constants;
  - `stereo_sample_t` struct {left, right};
  - `UNDERRUN_CNT_W`=16.
- Sub-module `i2s_clk_div`: `mc`/`bc` counters plus `sclk`/`ws`/strobe decode.
- Top level: buffer, consume logic, counter.

## Test plan
- Reset then `enable`=1: `frame_stb` at cycle 4; `sclk` period 4 (2 high, 2 low); `ws` rises at `bc`=31 and falls at `bc`=63; one `shift_stb` per 4 cycles, 64 per frame.
- Push (0x123456, 0xABCDEF) before the first frame: `tx_left`/`tx_right` equal those values from the first `frame_stb`; `in_ready` stays 1 afterward.
- Push two pairs back-to-back: second is stalled (`in_ready`=0) until the consume edge, is accepted in that same cycle, and appears at the next frame 256 cycles later.
- No input for 3 frames: `underrun_cnt`=3; `tx_*`=0, or the last pair with `I2S_CTRL_HOLD_LAST_EN`.
- Force `underrun_cnt`=0xFFFF and underrun again: count stays 0xFFFF.
- Deassert `reset_n` mid-frame with a full buffer: next cycle all outputs are at reset values and the buffer is empty; after release the first `frame_stb` is 4 cycles after `enable`.
